// File: rtl/conv_ctrl.sv
// Sequencing controller for a single-MAC 1-D valid-mode convolution datapath.
// Streams samples/taps into the datapath memories, then walks n and k to produce y[n].
module conv_ctrl #(
  parameter int AW_IN = 10,
  parameter int AW_K  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic            ld_kern,
  output logic            ld_ready,
  input  logic            ld_clr,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW_IN:0]  x_cnt,
  output logic [AW_K:0]   k_cnt,
  output logic [AW_IN-1:0] addr_in,
  output logic            wr_en_in,
  output logic [AW_K-1:0] addr_k,
  output logic            wr_en_k,
  output logic [AW_IN-1:0] addr_o,
  output logic            wr_en_o,
  output logic            clear_acc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [AW_IN:0] X_ONE = (AW_IN+1)'(1);
  localparam logic [AW_K:0]  K_ONE = (AW_K+1)'(1);

  state_t           state_q;
  logic [AW_IN:0]   x_cnt_q;
  logic [AW_K:0]    k_cnt_q;
  logic [AW_K:0]    kk_q;     // latched kernel length K
  logic [AW_IN:0]   m_q;      // latched output count M
  logic [AW_IN-1:0] n_q;
  logic [AW_K-1:0]  k_q;
  logic             err_q;

  logic             idle;
  logic             target_full;
  logic             load_fire;
  logic             start_bad;
  logic             last_k;
  logic             last_n;
  logic [AW_IN:0]   k_cnt_ext;

  // Counts saturate at exactly 2^AW, so the MSB alone flags a full memory.
  assign idle        = (state_q == S_IDLE);
  assign target_full = ld_kern ? k_cnt_q[AW_K] : x_cnt_q[AW_IN];
  assign ld_ready    = idle & ~start & ~target_full;
  assign load_fire   = ld_valid & ld_ready & ~ld_clr & ~rst;

  assign k_cnt_ext = {{(AW_IN-AW_K){1'b0}}, k_cnt_q};
  assign start_bad = (k_cnt_q == '0) || (x_cnt_q < k_cnt_ext);
  assign last_k    = ({1'b0, k_q} == (kk_q - K_ONE));
  assign last_n    = ({1'b0, n_q} == (m_q - X_ONE));

  assign x_cnt = x_cnt_q;
  assign k_cnt = k_cnt_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_cnt_q <= '0;
      k_cnt_q <= '0;
      kk_q    <= '0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            if (start_bad) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              kk_q    <= k_cnt_q;
              m_q     <= x_cnt_q - k_cnt_ext + X_ONE;
              n_q     <= '0;
              k_q     <= '0;
              state_q <= S_CLR;
            end
          end else if (ld_clr) begin
            x_cnt_q <= '0;
            k_cnt_q <= '0;
          end else if (load_fire) begin
            if (ld_kern) k_cnt_q <= k_cnt_q + K_ONE;
            else         x_cnt_q <= x_cnt_q + X_ONE;
          end
        end
        S_CLR: state_q <= S_MAC;
        S_MAC: begin
          if (last_k) state_q <= S_WR;
          else        k_q     <= k_q + 1'b1;
        end
        S_WR: begin
          if (last_n) begin
            state_q <= S_DONE;
          end else begin
            n_q     <= n_q + 1'b1;
            k_q     <= '0;
            state_q <= S_MAC;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    addr_in   = '0;
    wr_en_in  = 1'b0;
    addr_k    = '0;
    wr_en_k   = 1'b0;
    addr_o    = '0;
    wr_en_o   = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          if (ld_kern) begin
            wr_en_k = 1'b1;
            addr_k  = k_cnt_q[AW_K-1:0];
          end else begin
            wr_en_in = 1'b1;
            addr_in  = x_cnt_q[AW_IN-1:0];
          end
        end
      end
      S_CLR: begin
        busy      = 1'b1;
        clear_acc = 1'b1;
      end
      S_MAC: begin
        busy    = 1'b1;
        addr_in = n_q + {{(AW_IN-AW_K){1'b0}}, k_q};
        addr_k  = k_q;
      end
      S_WR: begin
        // Result write and accumulator clear land on the same edge.
        busy      = 1'b1;
        wr_en_o   = 1'b1;
        addr_o    = n_q;
        clear_acc = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl: a small datapath model plus a convolution
// reference computed directly from the loaded sample and tap lists.
module tb_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_kern, ld_clr, start;
  logic [7:0]  data_in;
  logic        ld_ready, busy, done, err;
  logic [10:0] x_cnt;
  logic [6:0]  k_cnt;
  logic [9:0]  addr_in, addr_o;
  logic [5:0]  addr_k;
  logic        wr_en_in, wr_en_k, wr_en_o, clear_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_ctrl #(.AW_IN(10), .AW_K(6)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_kern(ld_kern), .ld_ready(ld_ready),
    .ld_clr(ld_clr), .start(start), .busy(busy), .done(done), .err(err),
    .x_cnt(x_cnt), .k_cnt(k_cnt), .addr_in(addr_in), .wr_en_in(wr_en_in),
    .addr_k(addr_k), .wr_en_k(wr_en_k), .addr_o(addr_o), .wr_en_o(wr_en_o),
    .clear_acc(clear_acc)
  );

  // Datapath model: combinational reads, registered accumulator, edge writes.
  logic [7:0]  mem_x [1024];
  logic [7:0]  mem_h [64];
  logic [15:0] mem_y [1024];
  logic [15:0] acc = 16'h0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (wr_en_in) mem_x[addr_in] <= data_in;
    if (wr_en_k)  mem_h[addr_k]  <= data_in;
    if (wr_en_o) begin
      mem_y[addr_o] <= acc;
      wr_count      <= wr_count + 1;
    end
    acc <= clear_acc ? 16'h0
                     : acc + 16'(int'($signed(mem_h[addr_k])) * int'($signed(mem_x[addr_in])));
  end

  // Reference: what has been accepted into each memory, in load order.
  int hs[$];
  int xs[$];

  function automatic logic [15:0] ref_y(input int n);
    int s = 0;
    for (int k = 0; k < hs.size(); k++) s += hs[k] * xs[n+k];
    return 16'(s);
  endfunction

  task automatic load(input bit kern, input int val);
    bit exp_rdy;
    exp_rdy = kern ? (hs.size() < 64) : (xs.size() < 1024);
    @(negedge clk);
    ld_valid = 1'b1; ld_kern = kern; data_in = 8'(val);
    #1;
    checks++;
    if (ld_ready !== exp_rdy) begin
      errors++;
      $display("FAIL load_ready kern=%0b: got %0b expected %0b", kern, ld_ready, exp_rdy);
    end
    checks++;
    if (kern) begin
      if (wr_en_k !== exp_rdy || (exp_rdy && addr_k !== 6'(hs.size()))) begin
        errors++;
        $display("FAIL load_kstrobe: got we=%0b addr=%0d expected we=%0b addr=%0d",
                 wr_en_k, addr_k, exp_rdy, hs.size());
      end
      if (exp_rdy) hs.push_back(val);
    end else begin
      if (wr_en_in !== exp_rdy || (exp_rdy && addr_in !== 10'(xs.size()))) begin
        errors++;
        $display("FAIL load_xstrobe: got we=%0b addr=%0d expected we=%0b addr=%0d",
                 wr_en_in, addr_in, exp_rdy, xs.size());
      end
      if (exp_rdy) xs.push_back(val);
    end
  endtask

  task automatic release_load();
    @(negedge clk);
    ld_valid = 1'b0; ld_kern = 1'b0;
  endtask

  task automatic clear_counts();
    @(negedge clk);
    ld_clr = 1'b1; ld_valid = 1'b1; ld_kern = 1'b0;
    #1;
    checks++;
    if (wr_en_in !== 1'b0 || wr_en_k !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop: got we_in=%0b we_k=%0b expected 0", wr_en_in, wr_en_k);
    end
    @(negedge clk);
    ld_clr = 1'b0; ld_valid = 1'b0;
    #1;
    checks++;
    if (x_cnt !== 11'd0 || k_cnt !== 7'd0) begin
      errors++;
      $display("FAIL clr_counts: got x=%0d k=%0d expected 0", x_cnt, k_cnt);
    end
    hs.delete(); xs.delete();
  endtask

  // Starts a run and follows it to done, checking schedule, addresses and results.
  task automatic do_run(input bit with_load, output int busy_n);
    int  kk, nn, mm, exp_busy, wr0, n_seen, cyc;
    bit  exp_err, got_done, ok;
    int  mac_a[$];
    int  mac_k[$];
    kk = hs.size(); nn = xs.size();
    exp_err  = (kk == 0) || (nn < kk);
    mm       = exp_err ? 0 : nn - kk + 1;
    exp_busy = exp_err ? 0 : 1 + mm * (kk + 1);
    wr0 = wr_count; n_seen = 0; cyc = 0; got_done = 1'b0; busy_n = 0;
    @(negedge clk);
    start = 1'b1; ld_valid = with_load; ld_kern = 1'b0; data_in = 8'h5a;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || wr_en_in !== 1'b0) begin
      errors++;
      $display("FAIL start_prio: got ready=%0b we_in=%0b expected 0", ld_ready, wr_en_in);
    end
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    #1;
    while (!got_done && cyc < 20000) begin
      if (done) begin
        got_done = 1'b1;
      end else if (busy) begin
        busy_n++;
        if (wr_en_o) begin
          checks++;
          if (addr_o !== 10'(n_seen)) begin
            errors++;
            $display("FAIL wr_addr: got %0d expected %0d", addr_o, n_seen);
          end
          ok = (mac_a.size() == kk);
          for (int i = 0; i < mac_a.size(); i++)
            if (mac_a[i] != n_seen + i || mac_k[i] != i) ok = 1'b0;
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL mac_seq n=%0d: got %0d MAC cycles expected %0d in order", n_seen,
                     mac_a.size(), kk);
          end
          mac_a.delete(); mac_k.delete();
          n_seen++;
        end else if (!clear_acc) begin
          mac_a.push_back(int'(addr_in));
          mac_k.push_back(int'(addr_k));
        end else begin
          mac_a.delete(); mac_k.delete();
        end
        @(negedge clk); #1; cyc++;
      end else begin
        errors++;
        $display("FAIL run_idle: got busy=0 done=0 at cycle %0d expected busy or done", cyc);
        break;
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL run_done: got no done pulse expected one after %0d cycles", exp_busy);
    end else begin
      checks++;
      if (cyc != exp_busy || busy_n != exp_busy) begin
        errors++;
        $display("FAIL busy_len: got %0d expected %0d", busy_n, exp_busy);
      end
      checks++;
      if (err !== exp_err || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_err: got err=%0b busy=%0b expected err=%0b busy=0", err, busy, exp_err);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || ld_ready !== (xs.size() < 1024)) begin
      errors++;
      $display("FAIL back_idle: got done=%0b ready=%0b expected done=0 ready=1", done, ld_ready);
    end
    checks++;
    if (wr_count - wr0 != mm) begin
      errors++;
      $display("FAIL wr_count: got %0d expected %0d", wr_count - wr0, mm);
    end
    checks++;
    if (x_cnt !== 11'(nn) || k_cnt !== 7'(kk)) begin
      errors++;
      $display("FAIL counts_kept: got x=%0d k=%0d expected x=%0d k=%0d", x_cnt, k_cnt, nn, kk);
    end
    for (int n = 0; n < mm; n++) begin
      checks++;
      if (mem_y[n] !== ref_y(n)) begin
        errors++;
        $display("FAIL y[%0d]: got %0d expected %0d", n, $signed(mem_y[n]), $signed(ref_y(n)));
      end
    end
  endtask

  task automatic load_list(input bit kern, input int vals[$]);
    foreach (vals[i]) load(kern, vals[i]);
    release_load();
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b1; ld_kern = 1'b0; ld_clr = 1'b0; start = 1'b1; data_in = 8'h11;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, err, wr_en_in, wr_en_k, wr_en_o, clear_acc, ld_ready} !== 8'h0 ||
        {addr_in, addr_k, addr_o} !== 26'h0 || x_cnt !== 11'd0 || k_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ctrl=%b x=%0d k=%0d expected all 0",
               {busy, done, err, wr_en_in, wr_en_k, wr_en_o, clear_acc, ld_ready}, x_cnt, k_cnt);
    end
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || x_cnt !== 11'd0 || k_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_release: got ready=%0b x=%0d k=%0d expected 1,0,0", ld_ready, x_cnt, k_cnt);
    end
  endtask

  task automatic test_basic();
    int b;
    clear_counts();
    load_list(1'b1, '{1, 1, 1});
    load_list(1'b0, '{1, 2, 3, 4, 5, 6, 7, 8});
    do_run(1'b0, b);
    checks++;
    if (b != 25) begin
      errors++;
      $display("FAIL basic_busy: got %0d expected 25", b);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem_y[i] !== 16'(6 + 3*i)) begin
        errors++;
        $display("FAIL basic_y[%0d]: got %0d expected %0d", i, mem_y[i], 6 + 3*i);
      end
    end
  endtask

  task automatic test_edges();
    int b;
    clear_counts();
    load_list(1'b1, '{-2});
    load_list(1'b0, '{3, -4});
    do_run(1'b0, b);
    checks++;
    if (b != 5 || mem_y[0] !== 16'hfffa || mem_y[1] !== 16'd8) begin
      errors++;
      $display("FAIL k1: got busy=%0d y0=%0d y1=%0d expected 5,-6,8", b, $signed(mem_y[0]),
               $signed(mem_y[1]));
    end
    clear_counts();
    load_list(1'b1, '{3, -1, 2, 5});
    load_list(1'b0, '{7, 20, -9, 4});
    do_run(1'b0, b);
    checks++;
    if (b != 6) begin
      errors++;
      $display("FAIL kn_busy: got %0d expected 6", b);
    end
  endtask

  task automatic test_errors();
    int b;
    clear_counts();
    do_run(1'b0, b);
    load_list(1'b0, '{1, 2});
    load_list(1'b1, '{1, 2, 3});
    do_run(1'b0, b);
  endtask

  task automatic test_full();
    clear_counts();
    for (int i = 0; i < 65; i++) load(1'b1, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 1025; i++) load(1'b0, int'($urandom_range(0, 255)) - 128);
    release_load();
    #1;
    checks++;
    if (k_cnt !== 7'd64 || x_cnt !== 11'd1024) begin
      errors++;
      $display("FAIL full_counts: got x=%0d k=%0d expected 1024,64", x_cnt, k_cnt);
    end
  endtask

  task automatic test_midrun_reset();
    int wr0, c, b;
    clear_counts();
    load_list(1'b1, '{1, 1, 1});
    load_list(1'b0, '{1, 2, 3, 4, 5, 6, 7, 8});
    wr0 = wr_count;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (wr_count - wr0 < 2 && c < 200) begin
      @(negedge clk); c++;
    end
    #1;
    checks++;
    if (busy !== 1'b1 || clear_acc !== 1'b0 || addr_in !== 10'd2) begin
      errors++;
      $display("FAIL midrun_mac: got busy=%0b clr=%0b addr_in=%0d expected 1,0,2",
               busy, clear_acc, addr_in);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1 || x_cnt !== 11'd0 || k_cnt !== 7'd0) begin
      errors++;
      $display("FAIL midrun_rst: got busy=%0b done=%0b ready=%0b x=%0d k=%0d expected 0,0,1,0,0",
               busy, done, ld_ready, x_cnt, k_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_quiet: got done=%0b busy=%0b expected 0", done, busy);
      end
    end
    hs.delete(); xs.delete();
    load_list(1'b1, '{1, 1, 1});
    load_list(1'b0, '{1, 2, 3, 4, 5, 6, 7, 8});
    do_run(1'b0, b);
    checks++;
    if (b != 25 || mem_y[0] !== 16'd6 || mem_y[5] !== 16'd21) begin
      errors++;
      $display("FAIL rerun: got busy=%0d y0=%0d y5=%0d expected 25,6,21", b, mem_y[0], mem_y[5]);
    end
  endtask

  task automatic test_random();
    int kk, nn, ki, xi, b;
    bit kern;
    for (int it = 0; it < 4; it++) begin
      clear_counts();
      kk = int'($urandom_range(1, 8));
      nn = int'($urandom_range(kk, 30));
      ki = 0; xi = 0;
      while (ki < kk || xi < nn) begin
        kern = (ki < kk) && ((xi >= nn) || ($urandom_range(0, 1) == 1));
        load(kern, int'($urandom_range(0, 255)) - 128);
        if (kern) ki++; else xi++;
      end
      release_load();
      do_run(1'b0, b);
      do_run(1'b1, b);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_x[i] = 8'h0;
      mem_y[i] = 16'h0;
    end
    for (int i = 0; i < 64; i++) mem_h[i] = 8'h0;
    test_reset();
    test_basic();
    test_edges();
    test_errors();
    test_full();
    test_midrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
